trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  Sequences the MegaMapper I/O-trap datapath on the Nabu. It watches Z80 opcode fetches,
//  drives the opcode-capture/readback/control-write strobes of the register file, and
//  raises a timed NMI when a trapped I/O opcode executes while trapping is enabled. It
//  then holds the trap pending until the NMI handler acknowledges it through an I/O port.
// PARAMETERS
//  BASE_PORT   8'h40  I/O port base: BASE=ctrl write, BASE+1=opcode read, BASE+2=trap ack write
//  NMI_CYCLES  8      clk cycles nmi_n is held low per trap (1..255)
// PORTS
//  clk            in   1  system clock, all state on rising edge
//  reset_n        in   1  asynchronous active-low reset
//  m1_n           in   1  Z80 M1, async to clk
//  mreq_n         in   1  Z80 MREQ, async
//  iorq_n         in   1  Z80 IORQ, async
//  rd_n           in   1  Z80 RD, async
//  wr_n           in   1  Z80 WR, async
//  addr_lo        in   8  Z80 A[7:0], async
//  data_in        in   8  Z80 D[7:0] as seen by CPLD, async
//  trap_en        in   1  ctrl register bit: trapping armed
//  record_isr_en  out  1  comb: opcode fetch in progress (!m1_n & !mreq_n)
//  read_isr_en    out  1  comb: !iorq_n & addr_lo==BASE+1 & state==WAIT_ACK
//  write_ctrl_en  out  1  comb: !iorq_n & addr_lo==BASE_PORT
//  nmi_n          out  1  registered NMI to Z80, active low
//  trap_pending   out  1  registered, high in NMI and WAIT_ACK
//  trap_opcode    out  8  registered opcode (2nd byte if ED-prefixed) of last trap
//  trap_count     out  8  registered trap count, saturates at 8'hFF
// BEHAVIOUR
//  Sync: m1_n,mreq_n,iorq_n,rd_n,wr_n,addr_lo,data_in pass through 2 flops (reset: ctrl 1,
//   data/addr 0); all sequencing uses synced copies, so bus events are seen 2 clk late.
//  Fetch: shadow opcode loads synced data_in every clk with synced m1=0,mreq=0,rd=0.
//   Fetch-end = synced m1_n 0->1 while synced iorq_n was 1 (M1+IORQ = INTA, ignored).
//  Trap class: D3 (OUT (n),A), DB (IN A,(n)); ED then 01xxx000 / 01xxx001 (IN r,(C)/OUT (C),r).
//  Ack = first clk of synced iorq_n=0 & wr_n=0 & addr==BASE+2 (edge-qualified, once/cycle).
//  States (2-bit): IDLE, ED_SEEN, NMI, WAIT_ACK.
//   IDLE: fetch-end & trap_en: D3/DB -> NMI; ED -> ED_SEEN; else stay.
//   ED_SEEN: next fetch-end: trap-class -> NMI; else IDLE. trap_en=0 -> IDLE.
//   NMI entry: latch trap_opcode, trap_count+1 (hold at FF), load cnt=NMI_CYCLES, nmi_n=0.
//   NMI: cnt decrements each clk; nmi_n rises on clk cnt hits 0 -> WAIT_ACK.
//   WAIT_ACK: fetches ignored (handler code never traps); ack -> IDLE next clk.
//  trap_en falling in ED_SEEN/NMI/WAIT_ACK: -> IDLE next clk, nmi_n=1 immediately registered.
//  Ack during NMI: ignored; only honoured in WAIT_ACK.
//  Reset (any time, async): state=IDLE, nmi_n=1, trap_pending=0, trap_opcode=00,
//   trap_count=00, cnt=0, shadow=00. Comb strobes follow inputs even in reset.
//  Latency: fetch-end on bus -> nmi_n low = 3 clk (2 sync + 1 register).
// TESTING
//  1 trap_en=1, fetch D3, release m1 -> nmi_n low 3 clk later for exactly 8 clk,
//    trap_opcode=D3, trap_count=1, trap_pending=1 until ack write to port 42.
//  2 trap_en=1, fetch ED then 79 -> trap, trap_opcode=79; ED then 4B -> no trap, IDLE.
//  3 trap_en=0, fetch DB -> nmi_n stays 1, count 0; trap_en=1 then M1+IORQ INTA with DB
//    on bus -> no trap.
//  4 In WAIT_ACK: fetch DB -> no new trap; I/O read port 41 -> read_isr_en=1; in IDLE
//    port 41 read -> read_isr_en=0; ack write during NMI pulse -> ignored.
//  5 trap_en dropped mid-NMI (cycle 4) -> nmi_n=1 and IDLE next clk; reset_n pulsed in
//    WAIT_ACK -> all outputs to reset values without clk.
//  6 256 traps with acks -> trap_count saturates at FF, no wrap.

Source files
------------

// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
//   Sequences the MegaMapper I/O-trap datapath on the Nabu. Watches Z80 opcode
//   fetches, drives the opcode-capture/readback/control-write strobes of the
//   register file, raises a timed NMI when a trapped I/O opcode executes while
//   trapping is armed, and holds the trap pending until the handler acks it.
//
// Ports
//   clk            in   1  system clock, rising edge
//   reset_n        in   1  asynchronous active-low reset
//   m1_n..wr_n     in   1  Z80 bus controls (asynchronous to clk)
//   addr_lo        in   8  Z80 A[7:0] (asynchronous)
//   data_in        in   8  Z80 D[7:0] (asynchronous)
//   trap_en        in   1  trapping armed (control register bit, clk domain)
//   record_isr_en  out  1  comb: opcode fetch in progress
//   read_isr_en    out  1  comb: opcode readback port access while awaiting ack
//   write_ctrl_en  out  1  comb: control port access
//   nmi_n          out  1  registered NMI to Z80, active low
//   trap_pending   out  1  registered, high in NMI and WAIT_ACK
//   trap_opcode    out  8  registered opcode of the last trap
//   trap_count     out  8  registered trap count, saturating at 8'hFF
//   state_dbg      out  2  current FSM state (0 IDLE, 1 ED_SEEN, 2 NMI, 3 WAIT_ACK)
//
// Handshake note: there is no valid/ready pair here. Bus events are sampled
// through a 2-flop synchroniser, so every bus-driven decision happens 2 clk
// after the bus edge; the trap acknowledge is an edge-qualified pulse taken
// once per I/O write cycle.
// -----------------------------------------------------------------------------
module trap_sequencer #(
    parameter logic [7:0] BASE_PORT  = 8'h40,
    parameter int         NMI_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       m1_n,
    input  logic       mreq_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] addr_lo,
    input  logic [7:0] data_in,
    input  logic       trap_en,
    output logic       record_isr_en,
    output logic       read_isr_en,
    output logic       write_ctrl_en,
    output logic       nmi_n,
    output logic       trap_pending,
    output logic [7:0] trap_opcode,
    output logic [7:0] trap_count,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ED_SEEN  = 2'd1,
        S_NMI      = 2'd2,
        S_WAIT_ACK = 2'd3
    } state_t;

    localparam logic [7:0] PORT_OPC = BASE_PORT + 8'd1;
    localparam logic [7:0] PORT_ACK = BASE_PORT + 8'd2;
    localparam logic [7:0] NMI_LOAD = 8'(NMI_CYCLES);

    // Synchroniser: control bits packed {m1, mreq, iorq, rd, wr}, idle high.
    logic [4:0] ctl_s1, ctl_s2;
    logic [7:0] addr_s1, addr_s2;
    logic [7:0] data_s1, data_s2;
    logic       m1_q, iorq_q, ack_q;
    logic [7:0] shadow;

    logic m1_s, mreq_s, iorq_s, rd_s, wr_s;
    assign {m1_s, mreq_s, iorq_s, rd_s, wr_s} = ctl_s2;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       nmi_nxt, pending_nxt;
    logic [7:0] opcode_nxt, count_nxt;

    logic fetch_end, ack_cond, ack, is_direct, is_ed_class, enter_nmi;

    // Combinational strobes follow the raw bus, even while in reset.
    assign record_isr_en = !m1_n && !mreq_n;
    assign write_ctrl_en = !iorq_n && (addr_lo == BASE_PORT);
    assign read_isr_en   = !iorq_n && (addr_lo == PORT_OPC) && (state == S_WAIT_ACK);
    assign state_dbg     = state;

    // M1 rising while IORQ stayed high ends an opcode fetch; M1 together with
    // IORQ is an interrupt acknowledge and never counts as a fetch.
    assign fetch_end = m1_s && !m1_q && iorq_q;
    assign ack_cond  = !iorq_s && !wr_s && (addr_s2 == PORT_ACK);
    assign ack       = ack_cond && !ack_q;

    // OUT (n),A / IN A,(n), and the ED-prefixed IN r,(C) / OUT (C),r family.
    assign is_direct   = (shadow == 8'hD3) || (shadow == 8'hDB);
    assign is_ed_class = (shadow[7:6] == 2'b01) && (shadow[2:1] == 2'b00);

    // Synchroniser, edge detectors and opcode shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctl_s1  <= 5'b11111;
            ctl_s2  <= 5'b11111;
            addr_s1 <= 8'h00;
            addr_s2 <= 8'h00;
            data_s1 <= 8'h00;
            data_s2 <= 8'h00;
            m1_q    <= 1'b1;
            iorq_q  <= 1'b1;
            ack_q   <= 1'b0;
            shadow  <= 8'h00;
        end else begin
            ctl_s1  <= {m1_n, mreq_n, iorq_n, rd_n, wr_n};
            ctl_s2  <= ctl_s1;
            addr_s1 <= addr_lo;
            addr_s2 <= addr_s1;
            data_s1 <= data_in;
            data_s2 <= data_s1;
            m1_q    <= m1_s;
            iorq_q  <= iorq_s;
            ack_q   <= ack_cond;
            if (!m1_s && !mreq_s && !rd_s) begin
                shadow <= data_s2;
            end
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= 8'h00;
            nmi_n        <= 1'b1;
            trap_pending <= 1'b0;
            trap_opcode  <= 8'h00;
            trap_count   <= 8'h00;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            nmi_n        <= nmi_nxt;
            trap_pending <= pending_nxt;
            trap_opcode  <= opcode_nxt;
            trap_count   <= count_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fetch_end && trap_en) begin
                    if (is_direct) begin
                        state_nxt = S_NMI;
                    end else if (shadow == 8'hED) begin
                        state_nxt = S_ED_SEEN;
                    end
                end
            end
            S_ED_SEEN: begin
                if (!trap_en) begin
                    state_nxt = S_IDLE;
                end else if (fetch_end) begin
                    state_nxt = is_ed_class ? S_NMI : S_IDLE;
                end
            end
            S_NMI: begin
                // Acks are ignored here; only the pulse timer or disarm leaves.
                if (!trap_en) begin
                    state_nxt = S_IDLE;
                end else if (cnt <= 8'd1) begin
                    state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // Handler fetches are ignored; only ack or disarm leaves.
                if (!trap_en || ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        enter_nmi   = (state_nxt == S_NMI) && (state != S_NMI);
        nmi_nxt     = (state_nxt != S_NMI);
        pending_nxt = (state_nxt == S_NMI) || (state_nxt == S_WAIT_ACK);
        opcode_nxt  = trap_opcode;
        count_nxt   = trap_count;
        cnt_nxt     = cnt;
        if (enter_nmi) begin
            opcode_nxt = shadow;
            cnt_nxt    = NMI_LOAD;
            if (trap_count != 8'hFF) begin
                count_nxt = trap_count + 8'd1;
            end
        end else if (state == S_NMI) begin
            cnt_nxt = (state_nxt == S_NMI) ? (cnt - 8'd1) : 8'h00;
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [7:0] addr_lo = 8'h00, data_in = 8'h00;
    logic       trap_en = 1'b0;
    logic       record_isr_en, read_isr_en, write_ctrl_en, nmi_n, trap_pending;
    logic [7:0] trap_opcode, trap_count;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    trap_sequencer #(.BASE_PORT(8'h40), .NMI_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .addr_lo(addr_lo), .data_in(data_in), .trap_en(trap_en),
        .record_isr_en(record_isr_en), .read_isr_en(read_isr_en), .write_ctrl_en(write_ctrl_en),
        .nmi_n(nmi_n), .trap_pending(trap_pending), .trap_opcode(trap_opcode),
        .trap_count(trap_count), .state_dbg(state_dbg)
    );

    localparam logic [1:0] IDLE = 2'd0, ED_SEEN = 2'd1, NMI = 2'd2, WAIT_ACK = 2'd3;

    int total = 0;
    int bad   = 0;
    int model_count = 0;

    // ---------------- scoreboard: {trap_count, trap_opcode} per NMI ----------------
    logic [15:0] exp_q[$];

    task automatic expect_trap(input logic [7:0] op);
        if (model_count != 255) model_count++;
        exp_q.push_back({8'(model_count), op});
    endtask

    always @(negedge nmi_n) begin
        logic [15:0] e;
        #1;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_trap got count=%h opcode=%h required no trap", trap_count, trap_opcode);
        end else begin
            e = exp_q.pop_front();
            if ({trap_count, trap_opcode} !== e) begin
                bad++;
                $display("FAIL trap_record got count=%h opcode=%h required count=%h opcode=%h",
                         trap_count, trap_opcode, e[15:8], e[7:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_idle();
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic do_reset();
        bus_idle();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        model_count = 0;
        exp_q.delete();
        tick(1);
    endtask

    // Opcode fetch (or INTA when inta=1); returns just after releasing M1.
    task automatic fetch(input logic [7:0] op, input bit inta = 1'b0);
        data_in = op;
        m1_n = 1'b0;
        if (inta) iorq_n = 1'b0;
        else begin mreq_n = 1'b0; rd_n = 1'b0; end
        tick(3);
        bus_idle();
    endtask

    task automatic io_write(input logic [7:0] port);
        addr_lo = port; iorq_n = 1'b0; wr_n = 1'b0;
        tick(3);
        bus_idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++; if (nmi_n !== 1'b1) begin bad++; $display("FAIL reset_nmi got=%b required=1", nmi_n); end
        total++; if (trap_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b required=0", trap_pending); end
        total++; if ({trap_count, trap_opcode} !== 16'h0000) begin bad++; $display("FAIL reset_regs got=%h required=0000", {trap_count, trap_opcode}); end
        total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL reset_state got=%0d required=0", state_dbg); end
    endtask

    task automatic test_basic_trap();
        int lowc;
        trap_en = 1'b1;
        expect_trap(8'hD3);
        data_in = 8'hD3; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; #1;
        total++; if (record_isr_en !== 1'b1) begin bad++; $display("FAIL record_strobe got=%b required=1", record_isr_en); end
        tick(3);
        bus_idle();
        tick(2);
        total++; if (nmi_n !== 1'b1) begin bad++; $display("FAIL nmi_early got=%b required=1", nmi_n); end
        tick(1);
        total++; if (nmi_n !== 1'b0) begin bad++; $display("FAIL nmi_latency got=%b required=0", nmi_n); end
        total++; if (trap_pending !== 1'b1) begin bad++; $display("FAIL pending_in_nmi got=%b required=1", trap_pending); end
        lowc = 1;
        for (int k = 0; k < 20 && nmi_n === 1'b0; k++) begin tick(1); if (nmi_n === 1'b0) lowc++; end
        total++; if (lowc != 8) begin bad++; $display("FAIL nmi_width got=%0d required=8", lowc); end
        tick(3);
        total++; if (state_dbg !== WAIT_ACK || trap_pending !== 1'b1) begin bad++; $display("FAIL wait_ack got state=%0d pend=%b required state=3 pend=1", state_dbg, trap_pending); end
        io_write(8'h42);
        tick(2);
        total++; if (state_dbg !== IDLE || trap_pending !== 1'b0) begin bad++; $display("FAIL ack_release got state=%0d pend=%b required state=0 pend=0", state_dbg, trap_pending); end
    endtask

    task automatic test_ed_prefix();
        fetch(8'hED); tick(3);
        total++; if (state_dbg !== ED_SEEN) begin bad++; $display("FAIL ed_seen got=%0d required=1", state_dbg); end
        expect_trap(8'h79);
        fetch(8'h79); tick(14);
        total++; if (state_dbg !== WAIT_ACK) begin bad++; $display("FAIL ed_trap_state got=%0d required=3", state_dbg); end
        io_write(8'h42); tick(3);
        fetch(8'hED); tick(3);
        fetch(8'h4B); tick(14);
        total++; if (state_dbg !== IDLE || nmi_n !== 1'b1) begin bad++; $display("FAIL ed_no_trap got state=%0d nmi=%b required state=0 nmi=1", state_dbg, nmi_n); end
        total++; if (trap_count !== 8'd2) begin bad++; $display("FAIL ed_count got=%0d required=2", trap_count); end
    endtask

    task automatic test_disabled_and_inta();
        do_reset();
        trap_en = 1'b0;
        fetch(8'hDB); tick(14);
        total++; if (nmi_n !== 1'b1 || trap_count !== 8'd0) begin bad++; $display("FAIL disabled got nmi=%b count=%0d required nmi=1 count=0", nmi_n, trap_count); end
        trap_en = 1'b1;
        fetch(8'hDB, 1'b1); tick(14);
        total++; if (nmi_n !== 1'b1 || state_dbg !== IDLE) begin bad++; $display("FAIL inta got nmi=%b state=%0d required nmi=1 state=0", nmi_n, state_dbg); end
    endtask

    task automatic test_wait_ack_rules();
        expect_trap(8'hDB);
        fetch(8'hDB); tick(14);
        fetch(8'hDB); tick(14);
        total++; if (state_dbg !== WAIT_ACK || trap_count !== 8'd1) begin bad++; $display("FAIL wait_fetch got state=%0d count=%0d required state=3 count=1", state_dbg, trap_count); end
        addr_lo = 8'h41; iorq_n = 1'b0; rd_n = 1'b0; #1;
        total++; if (read_isr_en !== 1'b1) begin bad++; $display("FAIL read_strobe_wait got=%b required=1", read_isr_en); end
        tick(3); bus_idle();
        io_write(8'h42); tick(3);
        addr_lo = 8'h41; iorq_n = 1'b0; rd_n = 1'b0; #1;
        total++; if (read_isr_en !== 1'b0) begin bad++; $display("FAIL read_strobe_idle got=%b required=0", read_isr_en); end
        bus_idle();
        addr_lo = 8'h40; iorq_n = 1'b0; wr_n = 1'b0; #1;
        total++; if (write_ctrl_en !== 1'b1) begin bad++; $display("FAIL ctrl_strobe got=%b required=1", write_ctrl_en); end
        bus_idle(); tick(3);
        expect_trap(8'hD3);
        fetch(8'hD3); tick(5);
        io_write(8'h42); tick(8);
        total++; if (state_dbg !== WAIT_ACK || trap_pending !== 1'b1) begin bad++; $display("FAIL ack_in_nmi got state=%0d pend=%b required state=3 pend=1", state_dbg, trap_pending); end
        io_write(8'h42); tick(3);
    endtask

    task automatic test_abort_and_reset();
        expect_trap(8'hD3);
        fetch(8'hD3); tick(7);
        trap_en = 1'b0;
        tick(1);
        total++; if (nmi_n !== 1'b1 || state_dbg !== IDLE || trap_pending !== 1'b0) begin bad++; $display("FAIL disarm got nmi=%b state=%0d pend=%b required nmi=1 state=0 pend=0", nmi_n, state_dbg, trap_pending); end
        trap_en = 1'b1;
        expect_trap(8'hDB);
        fetch(8'hDB); tick(14);
        #2 reset_n = 1'b0;
        #1;
        total++; if ({nmi_n, trap_pending, trap_count, trap_opcode, state_dbg} !== {1'b1, 1'b0, 16'h0000, IDLE}) begin
            bad++; $display("FAIL async_reset got nmi=%b pend=%b count=%h opc=%h state=%0d required 1 0 00 00 0", nmi_n, trap_pending, trap_count, trap_opcode, state_dbg);
        end
        #1 reset_n = 1'b1;
        model_count = 0;
        tick(2);
    endtask

    task automatic test_saturation();
        do_reset();
        trap_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            expect_trap((i % 2 == 0) ? 8'hDB : 8'hD3);
            fetch((i % 2 == 0) ? 8'hDB : 8'hD3); tick(14);
            io_write(8'h42); tick(3);
        end
        total++; if (trap_count !== 8'hFF) begin bad++; $display("FAIL saturate got=%h required=ff", trap_count); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic_trap();
        test_ed_prefix();
        test_disabled_and_inta();
        test_wait_ack_rules();
        test_abort_and_reset();
        test_saturation();
        tick(2);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL missing_traps got pending=%0d required=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
